muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M/RV64M multiply-divide unit with valid/ready request and response handshakes. It is a parametrised successor to the ALU's multi-cycle multiply path. It adds:
- configurable operand width
- configurable multiply radix
- DIV/DIVU/REM/REMU
- a kill input for pipeline flush

It sits beside the integer ALU in the execute stage. The execute stage issues any instruction with funct7 = 0000001 here and stalls on `req_ready`/`rsp_valid`.

## Interface
- `XLEN`, default 32: operand and result width. Must be 32 or 64.
- `MUL_STEP`, default 1: multiplier bits retired per cycle. Must be 1, 2 or 4, and must divide XLEN.

Clocking: one clock. Reset is asynchronous and active-high.

Ports:
- `s_clk`  in  1  clock, all state on rising edge
- `s_reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request this cycle
- `req_funct3`  in  3  RV M encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `req_a`  in  XLEN  rs1 operand
- `req_b`  in  XLEN  rs2 operand
- `kill`  in  1  flush; abandons any in-flight operation
- `busy`  out  1  high in MUL, DIV or DONE states
- `rsp_valid`  out  1  `rsp_result` valid
- `rsp_ready`  in  1  consumer takes the response
- `rsp_result`  out  XLEN  registered result

## Operation
States: IDLE, MUL, DIV, DONE.

Accept:
- A request is accepted on a rising edge with `req_valid && req_ready && !kill`.
- On accept, the unit registers funct3 and the operand magnitudes, a result-negate flag, and a 64-bit/2·XLEN accumulator.
- `req_ready` = (IDLE || (DONE && rsp_ready)) && !s_reset. Back-to-back issue is allowed on the response-consume edge.

Signedness:
- a is signed for MUL, MULH, MULHSU, DIV and REM.
- b is signed for MUL, MULH, DIV and REM.
- Negative signed operands are two's-complement negated to magnitudes.
- negate = sign(a) XOR sign(b) for MUL*/DIV.
- negate = sign(a) for REM.

Special cases: the unit goes straight to DONE with no iterations.
- Divide by zero: DIV/DIVU result all-ones; REM/REMU result = a.
- Signed overflow (a = most-negative, b = −1) for DIV: result = a; for REM: result = 0.

Iterations:
- MUL: shift-add loop, MUL_STEP bits of b per cycle, XLEN/MUL_STEP iterations.
- DIV: restoring division, one quotient bit per cycle, XLEN iterations.
- An iteration counter of width $clog2(XLEN)+1 counts iterations. The FSM leaves the iteration state on the last count.

DONE entry:
- The sign-corrected 2·XLEN product or quotient/remainder is selected by funct3 and registered into `rsp_result`.
- MUL takes the low half. MULH, MULHSU and MULHU take the high half.

DONE exit:
- DONE holds `rsp_valid` and `rsp_result` stable until `rsp_ready`.
- If a new request is accepted on that same edge, the next state is MUL/DIV/DONE as appropriate. Otherwise the next state is IDLE.

Kill:
- Kill in any state forces IDLE on the next edge and drops `rsp_valid`.
- Kill in the same cycle as a request blocks that accept.
- Kill has priority over `rsp_ready`. A killed DONE response is not delivered.

Request inputs are ignored outside accept edges.

## Timing
- Reset values:
  - state IDLE
  - `rsp_valid` 0
  - `rsp_result` 0
  - `busy` 0
  - `req_ready` 0 while `s_reset` is high, 1 after release
  - counter and accumulators 0
- Reset asserted mid-operation discards the operation immediately (asynchronous).
- Latency, from accept edge E0 to the first edge after which `rsp_valid` = 1:
  - MUL*: XLEN/MUL_STEP + 1 edges (33 for defaults)
  - DIV/REM: XLEN + 1 edges
  - Special cases: 1 edge
- Throughput: one operation per latency period when `rsp_ready` is held high, with zero idle cycles between operations.
- `rsp_result` changes only on the edge entering DONE.

## Test plan
- MUL/MULH signed, a = 0xFFFFFFFF, b = 0x00000002, defaults:
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF.
  - `rsp_valid` exactly 33 edges after accept.
- MULHSU a = 0x80000000, b = 0xFFFFFFFF → 0x80000000. MULHU same operands → 0x7FFFFFFF. Repeat with MUL_STEP = 4: latency 9 edges, same results.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Latency 33 edges.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Overflow: DIV 0x80000000/−1 → 0x80000000; REM → 0. Each has latency 1 edge.
- Backpressure and back-to-back: hold `rsp_ready` = 0 for 10 cycles in DONE → result stable and `req_ready` = 0. Raise `rsp_ready` with a new `req_valid` → next request accepted on the same edge, with no IDLE cycle.
- Kill and reset: kill at iteration 5 of a DIV → IDLE next edge, no `rsp_valid`, `req_ready` = 1. Assert `s_reset` mid-MUL → all outputs 0 immediately. Kill with `req_valid` in IDLE → no accept.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// Shift-add multiply retires MUL_STEP multiplier bits per cycle; restoring divide one bit per cycle.
module muldiv_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            s_clk,
    input  logic            s_reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            busy,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned AW = 2 * XLEN;
    localparam logic [CW-1:0] MulLast = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0] DivLast = CW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] a_mag_q;
    logic [XLEN-1:0] b_mag_q;
    logic            negate_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic            is_div, div_zero, div_ovf, negate_d;
    logic [XLEN-1:0] a_mag_d, b_mag_d, special_result;

    logic [XLEN+MUL_STEP-1:0] mul_partial, mul_sum;
    logic [AW-1:0]            mul_next, div_next, iter_next, prod;
    logic [XLEN:0]            rem_shift, rem_diff;
    logic [XLEN-1:0]          quo, rem, final_result;
    logic                     last_iter;

    assign req_ready = ((state == StIdle) || ((state == StDone) && rsp_ready)) && !s_reset;
    assign accept    = req_valid && req_ready && !kill;

    // Request decode: operand magnitudes, sign of result and the no-iteration cases.
    always_comb begin
        a_signed = (req_funct3 != 3'b011) && (req_funct3 != 3'b101) && (req_funct3 != 3'b111);
        b_signed = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
        a_neg    = a_signed && req_a[XLEN-1];
        b_neg    = b_signed && req_b[XLEN-1];
        a_mag_d  = a_neg ? -req_a : req_a;
        b_mag_d  = b_neg ? -req_b : req_b;
        negate_d = (req_funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
        is_div   = req_funct3[2];
        div_zero = is_div && (req_b == '0);
        div_ovf  = is_div && !req_funct3[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (req_b == '1);
        if (div_zero) begin
            special_result = req_funct3[1] ? req_a : '1;
        end else begin
            special_result = req_funct3[1] ? '0 : req_a;
        end
    end

    // One iteration step for each algorithm and the sign-corrected result of the final step.
    always_comb begin
        mul_partial = {{MUL_STEP{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
        mul_sum     = {{MUL_STEP{1'b0}}, acc_q[AW-1:XLEN]} + mul_partial;
        mul_next    = {mul_sum, acc_q[XLEN-1:MUL_STEP]};

        rem_shift = acc_q[AW-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, b_mag_q};
        if (!rem_diff[XLEN]) begin
            div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        iter_next = (state == StDiv) ? div_next : mul_next;
        prod      = negate_q ? -iter_next : iter_next;
        quo       = negate_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
        rem       = negate_q ? -iter_next[AW-1:XLEN] : iter_next[AW-1:XLEN];

        unique case (funct3_q)
            3'b000:                 final_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod[AW-1:XLEN];
            3'b100, 3'b101:         final_result = quo;
            default:                final_result = rem;
        endcase

        last_iter = (state == StDiv) ? (cnt_q == DivLast) : (cnt_q == MulLast);
    end

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            state      <= StIdle;
            funct3_q   <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            negate_q   <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
        end else if (kill) begin
            state     <= StIdle;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else if (accept) begin
            funct3_q <= req_funct3;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            negate_q <= negate_d;
            cnt_q    <= '0;
            busy     <= 1'b1;
            if (div_zero || div_ovf) begin
                state      <= StDone;
                rsp_result <= special_result;
                rsp_valid  <= 1'b1;
            end else if (is_div) begin
                state     <= StDiv;
                acc_q     <= {{XLEN{1'b0}}, a_mag_d};
                rsp_valid <= 1'b0;
            end else begin
                state     <= StMul;
                acc_q     <= {{XLEN{1'b0}}, b_mag_d};
                rsp_valid <= 1'b0;
            end
        end else begin
            unique case (state)
                StMul, StDiv: begin
                    acc_q <= iter_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        state      <= StDone;
                        rsp_result <= final_result;
                        rsp_valid  <= 1'b1;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with a result scoreboard, plus handshake,
// kill and reset sequences. A second instance covers MUL_STEP = 4.
module tb_muldiv_unit;
    logic        s_clk = 1'b0;
    logic        s_reset;
    logic        req_valid, kill, rsp_ready, sel;
    logic [2:0]  req_funct3;
    logic [31:0] req_a, req_b;

    logic        req_ready0, busy0, rsp_valid0;
    logic        req_ready4, busy4, rsp_valid4;
    logic [31:0] rsp_result0, rsp_result4;
    logic        req_ready_m, busy_m, rsp_valid_m;
    logic [31:0] rsp_result_m;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          sel;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    always #5 s_clk = ~s_clk;

    muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
        .s_clk      (s_clk),
        .s_reset    (s_reset),
        .req_valid  (req_valid && !sel),
        .req_ready  (req_ready0),
        .req_funct3 (req_funct3),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .busy       (busy0),
        .rsp_valid  (rsp_valid0),
        .rsp_ready  (rsp_ready && !sel),
        .rsp_result (rsp_result0)
    );

    muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
        .s_clk      (s_clk),
        .s_reset    (s_reset),
        .req_valid  (req_valid && sel),
        .req_ready  (req_ready4),
        .req_funct3 (req_funct3),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .busy       (busy4),
        .rsp_valid  (rsp_valid4),
        .rsp_ready  (rsp_ready && sel),
        .rsp_result (rsp_result4)
    );

    assign req_ready_m  = sel ? req_ready4  : req_ready0;
    assign busy_m       = sel ? busy4       : busy0;
    assign rsp_valid_m  = sel ? rsp_valid4  : rsp_valid0;
    assign rsp_result_m = sel ? rsp_result4 : rsp_result0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge with req_valid dropped.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        if (push) exp_q.push_back(exp);
        #1;
        check("issue_ready", 64'(req_ready_m), 64'd1);
        @(posedge s_clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom();
        req_b     = $urandom();
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic await_rsp(input int lat, input string name);
        int n = 1;
        logic [31:0] e;
        while (!rsp_valid_m && n < 200) begin
            @(posedge s_clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_result"}, 64'(rsp_result_m), 64'(e));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        s_reset    = 1'b1;
        req_valid  = 1'b0;
        kill       = 1'b0;
        rsp_ready  = 1'b1;
        sel        = 1'b0;
        req_funct3 = '0;
        req_a      = '0;
        req_b      = '0;

        vecs.push_back('{1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 33});
        vecs.push_back('{1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{1'b0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back('{1'b0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33});
        vecs.push_back('{1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{1'b0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
        vecs.push_back('{1'b0, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{1'b0, 3'b101, 32'd100,       32'd7,         32'd14,        33});
        vecs.push_back('{1'b0, 3'b111, 32'd100,       32'd7,         32'd2,         33});
        vecs.push_back('{1'b0, 3'b100, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33});
        vecs.push_back('{1'b0, 3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33});
        vecs.push_back('{1'b0, 3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33});
        vecs.push_back('{1'b0, 3'b110, 32'd100,       32'hFFFF_FFF9, 32'd2,         33});
        vecs.push_back('{1'b0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
        vecs.push_back('{1'b0, 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back('{1'b0, 3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{1'b0, 3'b110, 32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{1'b0, 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{1'b0, 3'b111, 32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
        vecs.push_back('{1'b1, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 9});
        vecs.push_back('{1'b1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 9});
        vecs.push_back('{1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 9});
        vecs.push_back('{1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 9});
        vecs.push_back('{1'b1, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});

        #12;
        check("reset_outputs", {req_ready_m, busy_m, rsp_valid_m, rsp_result_m}, 64'd0);
        check("reset_outputs_step4", {req_ready4, busy4, rsp_valid4, rsp_result4}, 64'd0);
        @(negedge s_clk);
        s_reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(req_ready_m), 64'd1);
        @(posedge s_clk);
        #1;

        // Consecutive vectors issue on the response-consume edge.
        foreach (vecs[i]) begin
            if (vecs[i].sel != sel) begin
                @(posedge s_clk);
                #1;
                sel = vecs[i].sel;
            end
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            await_rsp(vecs[i].lat, $sformatf("vec%0d", i));
        end
        @(posedge s_clk);
        #1;
        sel = 1'b0;

        // Backpressure in DONE, then back-to-back accept on the consume edge.
        rsp_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
        await_rsp(33, "bp_divu");
        for (int i = 0; i < 10; i++) begin
            @(posedge s_clk);
            #1;
            check($sformatf("bp_hold%0d", i), {rsp_valid_m, req_ready_m, rsp_result_m},
                  {1'b1, 1'b0, 32'd14});
        end
        rsp_ready = 1'b1;
        issue(3'b111, 32'd100, 32'd7, 32'd2, 1'b1);
        check("b2b_no_idle", {busy_m, rsp_valid_m}, 64'b10);
        await_rsp(33, "b2b_remu");
        @(posedge s_clk);
        #1;

        // Kill during a divide.
        issue(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (4) @(posedge s_clk);
        #1;
        kill = 1'b1;
        @(posedge s_clk);
        #1;
        kill = 1'b0;
        check("kill_idle", {busy_m, rsp_valid_m, req_ready_m}, 64'b001);
        seen = 1'b0;
        repeat (40) begin
            @(posedge s_clk);
            #1;
            if (rsp_valid_m) seen = 1'b1;
        end
        check("kill_no_rsp", 64'(seen), 64'd0);

        // Kill alongside a request in IDLE blocks the accept.
        kill       = 1'b1;
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_a      = 32'd3;
        req_b      = 32'd3;
        @(posedge s_clk);
        #1;
        kill      = 1'b0;
        req_valid = 1'b0;
        check("kill_blocks_accept", {busy_m, rsp_valid_m}, 64'd0);
        repeat (40) @(posedge s_clk);
        #1;

        // Kill beats rsp_ready in DONE.
        rsp_ready = 1'b0;
        issue(3'b100, 32'd5, 32'd0, 32'd0, 1'b0);
        check("special_done", {rsp_valid_m, rsp_result_m}, {1'b1, 32'hFFFF_FFFF});
        kill      = 1'b1;
        rsp_ready = 1'b1;
        @(posedge s_clk);
        #1;
        kill = 1'b0;
        check("kill_done", {busy_m, rsp_valid_m}, 64'd0);

        // Asynchronous reset mid-multiply.
        issue(3'b000, 32'd3, 32'd5, 32'd0, 1'b0);
        repeat (6) @(posedge s_clk);
        #1;
        s_reset = 1'b1;
        #1;
        check("reset_async", {busy_m, rsp_valid_m, req_ready_m, rsp_result_m}, 64'd0);
        @(negedge s_clk);
        s_reset = 1'b0;
        #1;
        check("ready_after_reset2", 64'(req_ready_m), 64'd1);
        @(posedge s_clk);
        #1;
        issue(3'b000, 32'd7, 32'd6, 32'd42, 1'b1);
        await_rsp(33, "post_reset_mul");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
